// File: rtl/mem_ctrl_arbiter.sv
// Shares the main-memory controller port between icache and dcache miss paths.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise dcache has fixed priority.

package mem_ctrl_arbiter_pkg;
  typedef logic [25:0]  main_mem_block_addr_t;
  typedef logic [127:0] block_data_t;
  typedef logic         req_type_t;
  localparam req_type_t REQ_READ  = 1'b0;
  localparam req_type_t REQ_WRITE = 1'b1;
endpackage

module mem_ctrl_arbiter
  import mem_ctrl_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 icache_req_valid,
  input  main_mem_block_addr_t icache_req_block_addr,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,
  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data,
  output logic                 mem_req_valid,
  output req_type_t            mem_req_type,
  output main_mem_block_addr_t mem_req_block_addr,
  output block_data_t          mem_req_block_data,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  block_data_t          mem_resp_block_data,
  output logic                 protocol_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  typedef enum logic {ICACHE, DCACHE} owner_t;

  state_t               state_q, state_d;
  owner_t               owner_q, last_grant_q, winner;
  logic                 accept;
  req_type_t            type_q;
  main_mem_block_addr_t addr_q;
  block_data_t          data_q;
  logic                 err_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, hand the port to whoever did not win last time
  assign winner = (dcache_req_valid && (!icache_req_valid || last_grant_q == ICACHE)) ? DCACHE : ICACHE;
`else
  assign winner = dcache_req_valid ? DCACHE : ICACHE;
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    icache_req_ready  = 1'b0;
    dcache_req_ready  = 1'b0;
    mem_req_valid     = 1'b0;
    icache_resp_valid = 1'b0;
    dcache_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (icache_req_valid || dcache_req_valid) begin
          accept = 1'b1;
          if (winner == DCACHE) dcache_req_ready = 1'b1;
          else                  icache_req_ready = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = (type_q == REQ_WRITE) ? IDLE : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          if (owner_q == DCACHE) dcache_resp_valid = 1'b1;
          else                   icache_resp_valid = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q      <= IDLE;
      owner_q      <= ICACHE;
      last_grant_q <= ICACHE;
      type_q       <= REQ_READ;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= winner;
        last_grant_q <= winner;
        // Icache misses are always block reads carrying no data
        if (winner == DCACHE) begin
          type_q <= dcache_req_type;
          addr_q <= dcache_req_block_addr;
          data_q <= dcache_req_block_data;
        end else begin
          type_q <= REQ_READ;
          addr_q <= icache_req_block_addr;
          data_q <= '0;
        end
      end
      if (mem_resp_valid && state_q != WAIT_RESP) err_q <= 1'b1;
    end
  end

  assign mem_req_type           = type_q;
  assign mem_req_block_addr     = addr_q;
  assign mem_req_block_data     = data_q;
  assign icache_resp_block_data = mem_resp_block_data;
  assign dcache_resp_block_data = mem_resp_block_data;
  assign protocol_err           = err_q;

endmodule
